uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the peripheral's UART transmitter.
- Synchronises the asynchronous rxd pin, finds the start bit, samples PAYLOAD_BITS data bits LSB-first at mid-bit, and checks the stop bit.
- Holds one received byte in a single-entry buffer with a valid/read handshake, and reports overrun and framing errors.
- Bit timing matches the transmitter exactly: one bit lasts CYCLES_PER_BIT+1 clocks, where CYCLES_PER_BIT = (CLK_HZ-1)/BIT_RATE.

Parameters:
- BIT_RATE, 9600: line bit rate, bits/s.
- CLK_HZ, 50_000_000: clk frequency, Hz.
- PAYLOAD_BITS, 8: data bits per frame.
- STOP_BITS, 1: stop bits expected; only the first is checked.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; synchronous, active-low (see Behaviour).
- uart_rxd  input  1  asynchronous serial input, idle high.
- uart_rx_data  output  PAYLOAD_BITS  last good received word.
- uart_rx_valid  output  1  uart_rx_data holds an unread word.
- uart_rx_read  input  1  consumer pops the buffer; single-cycle strobe.
- uart_rx_overrun  output  1  sticky: a word completed while valid=1 and no read that cycle.
- uart_rx_ferr  output  1  one-cycle pulse: stop bit sampled low.
- uart_rx_busy  output  1  high in states START, DATA, STOP.

Behaviour:
- Clock and reset: reset resetn, synchronous, active-low; clock clk.
- Reset values: data=0, valid=0, overrun=0, ferr=0, busy=0, state=WAIT_HIGH, counters=0, synchroniser flops=1.
- Reset mid-frame abandons the frame; no valid or ferr is produced.
- Synchroniser: two flops produce rxd_s. All decisions use rxd_s. Pin-to-rxd_s latency is 2 clocks.
- Counter: cnt, width 1+$clog2(CYCLES_PER_BIT). Increments each clock in START/DATA/STOP and clears to 0 on every state change and on every bit sample.
- Sample value: rxd_s; majority value when the optional feature is enabled.
- FSM:
  - WAIT_HIGH: go to IDLE when rxd_s=1. Prevents a stuck-low line from being read as a start bit.
  - IDLE: when rxd_s=0, go to START with cnt=0.
  - START: at cnt==CYCLES_PER_BIT/2 (integer division), sample. If 0, go to DATA with bit index 0. If 1 (glitch), go back to IDLE with no flags.
  - DATA: at cnt==CYCLES_PER_BIT, shift the sample into the MSB of the shift register (shift right). After PAYLOAD_BITS samples, go to STOP.
  - STOP: at cnt==CYCLES_PER_BIT, sample.
    - If 1: load uart_rx_data from the shift register, set valid, go to IDLE.
    - If 0: pulse ferr for one cycle, leave data and valid unchanged, go to WAIT_HIGH.
- Timing: every sample falls mid-bit. Valid rises 2 + CYCLES_PER_BIT/2 + (PAYLOAD_BITS+1)×(CYCLES_PER_BIT+1) + 1 clocks after the start-bit falling edge at the pin.
- Extra stop bits (STOP_BITS>1) are absorbed by IDLE as line-high time.
- Handshake:
  - uart_rx_read with valid=1 clears valid next cycle.
  - uart_rx_read with valid=0 has no effect.
- Simultaneous word completion and read: the new word loads, valid stays 1, overrun is not set.
- Completion while valid=1 with no read: data is overwritten with the new word, overrun is set.
- Overrun clears on the next uart_rx_read or on reset.
- CYCLES_PER_BIT must be at least 4.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - A 3-bit history of rxd_s shifts every clock.
  - Each sample value, including the START check, is the 2-of-3 majority of the history. The history is taken at the same cnt sample points.
  - A single-cycle glitch at the sample point is rejected.
  - The IDLE start detect still uses raw rxd_s.
  - History resets to 3'b111.
- Undefined: the sample value is rxd_s at the sample point. The history register is not built.

Test Plan (CLK_HZ=1_000_000, BIT_RATE=125_000, so CYCLES_PER_BIT=7 and 8 clocks/bit):
- Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop=1) -> valid rises exactly at the computed latency, data=0xA5, ferr=0; read strobe -> valid=0 next clock.
- Two back-to-back frames 0x3C then 0xC3, no read -> data=0xC3, valid=1, overrun=1; read -> valid=0, overrun=0.
- Second frame completes on the same cycle as a read of the first -> data updates, valid=1, overrun=0.
- Frame 0x55 with stop bit low -> one-cycle ferr, valid unchanged. Hold line low 40 clocks then high -> no new start until the line has been seen high; next frame 0x12 received correctly.
- 2-clock low glitch on an idle line -> FSM returns to IDLE from START with no valid and no ferr. With UART_RX_MAJORITY_EN: a 1-clock high glitch at the mid-bit of data bit 3 of 0x00 -> data=0x00. Without the macro -> data=0x08.
- Assert resetn low mid-DATA for 1 clock -> all outputs at reset values; next full frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, single-entry buffer with overrun/ferr.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote over recent rxd_s history.
module uart_rx #(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  input  logic                    uart_rx_read,
  output logic                    uart_rx_overrun,
  output logic                    uart_rx_ferr,
  output logic                    uart_rx_busy
);

  localparam int unsigned CyclesPerBit = (CLK_HZ - 1) / BIT_RATE;
  localparam int unsigned CntW         = 1 + $clog2(CyclesPerBit);
  localparam int unsigned IdxW         = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [CntW-1:0] CntMid   = CntW'(CyclesPerBit / 2);
  localparam logic [CntW-1:0] CntEnd   = CntW'(CyclesPerBit);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(PAYLOAD_BITS - 1);

  if (CyclesPerBit < 4 || STOP_BITS < 1) begin : g_param_check
    $error("uart_rx: CYCLES_PER_BIT must be >= 4 and STOP_BITS >= 1");
  end

  typedef enum logic [2:0] {
    StWaitHigh,
    StIdle,
    StStart,
    StData,
    StStop
  } state_t;

  state_t                  state_q, state_d;
  logic                    rxd_m_q, rxd_m_d, rxd_s_q, rxd_s_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                    valid_q, valid_d, overrun_q, overrun_d;
  logic                    ferr_q, ferr_d, busy_q, busy_d;
  logic                    sample;

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist_q, hist_d;

  // The vote includes the current rxd_s, so a lone glitch at the sample point is outvoted.
  always_comb begin
    hist_d = {hist_q[1:0], rxd_s_q};
    sample = (hist_d[0] & hist_d[1]) | (hist_d[0] & hist_d[2]) | (hist_d[1] & hist_d[2]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) hist_q <= 3'b111;
    else         hist_q <= hist_d;
  end
`else
  assign sample = rxd_s_q;
`endif

  always_comb begin
    rxd_m_d   = uart_rxd;
    rxd_s_d   = rxd_m_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;

    if (uart_rx_read) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StWaitHigh: if (rxd_s_q) state_d = StIdle;
      StIdle: begin
        if (!rxd_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntMid) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sample ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntEnd) begin
          cnt_d   = '0;
          shreg_d = (shreg_q >> 1) | (PAYLOAD_BITS'(sample) << (PAYLOAD_BITS - 1));
          if (idx_q == IdxLast) state_d = StStop;
          else                  idx_d   = idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntEnd) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            // A read on the completion cycle consumes the old word, so no overrun.
            if (valid_q && !uart_rx_read) overrun_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StWaitHigh;
    endcase

    busy_d = state_d inside {StStart, StData, StStop};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_m_q   <= 1'b1;
      rxd_s_q   <= 1'b1;
      state_q   <= StWaitHigh;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rxd_m_q   <= rxd_m_d;
      rxd_s_q   <= rxd_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign uart_rx_data    = data_q;
  assign uart_rx_valid   = valid_q;
  assign uart_rx_overrun = overrun_q;
  assign uart_rx_ferr    = ferr_q;
  assign uart_rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks/bit (CYCLES_PER_BIT=7).
// Edge 0 is the first clock edge that captures a frame's start bit at the pin.
module tb_uart_rx;

  logic       clk;
  logic       resetn;
  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_read;
  logic       uart_rx_overrun;
  logic       uart_rx_ferr;
  logic       uart_rx_busy;

  int n_cmp = 0;
  int n_err = 0;
  int rise_edge;
  int ferr_cnt;
  logic busy_mid;

  // 2 + 7/2 + 9*8 + 1
  localparam int ValidLatency = 78;

  uart_rx #(
    .BIT_RATE    (125_000),
    .CLK_HZ      (1_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .uart_rxd       (uart_rxd),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_read   (uart_rx_read),
    .uart_rx_overrun(uart_rx_overrun),
    .uart_rx_ferr   (uart_rx_ferr),
    .uart_rx_busy   (uart_rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    tick(n);
  endtask

  task automatic do_read();
    uart_rx_read = 1'b1;
    tick(1);
    uart_rx_read = 1'b0;
  endtask

  // Drives one 10-bit frame; pin value for edge i is set just after edge i-1.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int read_edge,
                            input int glitch_edge);
    logic [9:0] bits;
    logic vprev;
    int nxt;
    bits      = {stop_v, d, 1'b0};
    rise_edge = -1;
    ferr_cnt  = 0;
    busy_mid  = 1'b0;
    vprev     = uart_rx_valid;
    uart_rxd  = bits[0];
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (uart_rx_valid && !vprev && rise_edge < 0) rise_edge = i;
      vprev = uart_rx_valid;
      if (uart_rx_ferr) ferr_cnt++;
      if (i == 40) busy_mid = uart_rx_busy;
      if (i == read_edge - 1) uart_rx_read = 1'b1;
      if (i == read_edge) uart_rx_read = 1'b0;
      nxt = i + 1;
      if (nxt < 80) uart_rxd = bits[nxt/8] ^ (nxt == glitch_edge);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    uart_rxd = 1'b1;
    uart_rx_read = 1'b0;
    tick(3);
    n_cmp++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun, uart_rx_ferr, uart_rx_busy} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h v=%b o=%b f=%b b=%b want all zero",
               uart_rx_data, uart_rx_valid, uart_rx_overrun, uart_rx_ferr, uart_rx_busy);
    end
    resetn = 1'b1;
    idle(10);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, -1, -1);
    n_cmp++;
    if (rise_edge != ValidLatency) begin
      n_err++; $display("FAIL a5_latency: got %0d want %0d", rise_edge, ValidLatency);
    end
    n_cmp++;
    if (uart_rx_data !== 8'hA5) begin
      n_err++; $display("FAIL a5_data: got %h want a5", uart_rx_data);
    end
    n_cmp++;
    if (ferr_cnt != 0) begin
      n_err++; $display("FAIL a5_ferr: got %0d pulses want 0", ferr_cnt);
    end
    n_cmp++;
    if (busy_mid !== 1'b1) begin
      n_err++; $display("FAIL a5_busy_mid: got %b want 1", busy_mid);
    end
    idle(4);
    n_cmp++;
    if (uart_rx_busy !== 1'b0) begin
      n_err++; $display("FAIL a5_busy_idle: got %b want 0", uart_rx_busy);
    end
    do_read();
    n_cmp++;
    if (uart_rx_valid !== 1'b0) begin
      n_err++; $display("FAIL a5_read_clears: got valid=%b want 0", uart_rx_valid);
    end
    do_read();
    n_cmp++;
    if ({uart_rx_valid, uart_rx_overrun, uart_rx_data} !== {2'b00, 8'hA5}) begin
      n_err++;
      $display("FAIL read_when_empty: got v=%b o=%b d=%h want v=0 o=0 d=a5",
               uart_rx_valid, uart_rx_overrun, uart_rx_data);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, -1, -1);
    send_frame(8'hC3, 1'b1, -1, -1);
    idle(4);
    n_cmp++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun} !== {8'hC3, 2'b11}) begin
      n_err++;
      $display("FAIL overrun_set: got d=%h v=%b o=%b want d=c3 v=1 o=1",
               uart_rx_data, uart_rx_valid, uart_rx_overrun);
    end
    do_read();
    n_cmp++;
    if ({uart_rx_valid, uart_rx_overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL overrun_clear: got v=%b o=%b want v=0 o=0", uart_rx_valid, uart_rx_overrun);
    end
  endtask

  task automatic test_read_collide();
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, ValidLatency, -1);
    idle(2);
    n_cmp++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun} !== {8'h22, 2'b10}) begin
      n_err++;
      $display("FAIL collide: got d=%h v=%b o=%b want d=22 v=1 o=0",
               uart_rx_data, uart_rx_valid, uart_rx_overrun);
    end
    do_read();
  endtask

  task automatic test_ferr();
    send_frame(8'h66, 1'b1, -1, -1);
    send_frame(8'h55, 1'b0, -1, -1);
    n_cmp++;
    if (ferr_cnt != 1) begin
      n_err++; $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_cnt);
    end
    n_cmp++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun} !== {8'h66, 2'b10}) begin
      n_err++;
      $display("FAIL ferr_keeps_buffer: got d=%h v=%b o=%b want d=66 v=1 o=0",
               uart_rx_data, uart_rx_valid, uart_rx_overrun);
    end
    tick(40);
    n_cmp++;
    if (uart_rx_busy !== 1'b0) begin
      n_err++; $display("FAIL stuck_low_no_start: got busy=%b want 0", uart_rx_busy);
    end
    idle(12);
    do_read();
    send_frame(8'h12, 1'b1, -1, -1);
    n_cmp++;
    if (rise_edge != ValidLatency || uart_rx_data !== 8'h12) begin
      n_err++;
      $display("FAIL after_ferr_frame: got d=%h rise=%0d want d=12 rise=%0d",
               uart_rx_data, rise_edge, ValidLatency);
    end
    do_read();
  endtask

  task automatic test_glitch();
    logic busy_seen, bad_seen;
    busy_seen = 1'b0;
    bad_seen  = 1'b0;
    idle(5);
    uart_rxd = 1'b0;
    tick(2);
    uart_rxd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (uart_rx_busy) busy_seen = 1'b1;
      if (uart_rx_valid || uart_rx_ferr) bad_seen = 1'b1;
    end
    n_cmp++;
    if (busy_seen !== 1'b1) begin
      n_err++; $display("FAIL glitch_start_seen: got busy_seen=%b want 1", busy_seen);
    end
    n_cmp++;
    if ({bad_seen, uart_rx_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL glitch_rejected: got flags=%b busy=%b want 0 0", bad_seen, uart_rx_busy);
    end
  endtask

  task automatic test_majority();
    logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'h00;
`else
    exp = 8'h08;
`endif
    send_frame(8'h00, 1'b1, -1, 36);
    n_cmp++;
    if ({uart_rx_data, uart_rx_valid} !== {exp, 1'b1}) begin
      n_err++;
      $display("FAIL data_glitch: got d=%h v=%b want d=%h v=1", uart_rx_data, uart_rx_valid, exp);
    end
    idle(4);
    do_read();
  endtask

  task automatic test_reset_mid();
    send_frame(8'h81, 1'b1, -1, -1);
    send_frame(8'h42, 1'b1, -1, -1);
    uart_rxd = 1'b0;
    tick(30);
    n_cmp++;
    if ({uart_rx_busy, uart_rx_valid, uart_rx_overrun} !== 3'b111) begin
      n_err++;
      $display("FAIL pre_reset_state: got b=%b v=%b o=%b want 1 1 1",
               uart_rx_busy, uart_rx_valid, uart_rx_overrun);
    end
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    n_cmp++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun, uart_rx_ferr, uart_rx_busy} !== 12'h0) begin
      n_err++;
      $display("FAIL mid_reset: got d=%h v=%b o=%b f=%b b=%b want all zero",
               uart_rx_data, uart_rx_valid, uart_rx_overrun, uart_rx_ferr, uart_rx_busy);
    end
    idle(12);
    send_frame(8'h7E, 1'b1, -1, -1);
    n_cmp++;
    if (rise_edge != ValidLatency || uart_rx_data !== 8'h7E || ferr_cnt != 0) begin
      n_err++;
      $display("FAIL after_reset_frame: got d=%h rise=%0d ferr=%0d want d=7e rise=%0d ferr=0",
               uart_rx_data, rise_edge, ferr_cnt, ValidLatency);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_read_collide();
    test_ferr();
    test_glitch();
    test_majority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
